usb_tx_seq: RTL and testbench

USB_TX_SEQ -- requirements
Module: usb_tx_seq

---
 rtl/usb_pkg.sv | 30 +++
 rtl/usb_tx_nrzi.sv | 46 ++++
 rtl/usb_tx_seq.sv | 156 +++++++++++++++
 tb/tb_usb_tx_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB line-level types and constants, plus the transmit sequencer state type.
package usb_pkg;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_J   = 2'b01,
        LS_K   = 2'b10,
        LS_SE1 = 2'b11
    } usb_line_state_t;

    // Element 7 goes out first.
    localparam logic [7:0][1:0] USB_SYNC_PATTERN = {LS_K, LS_J, LS_K, LS_J, LS_K, LS_J, LS_K, LS_K};
    localparam logic [2:0][1:0] USB_EOP_PATTERN  = {LS_SE0, LS_SE0, LS_J};

    localparam int USB_STUFF_BITS_N    = 6;
    localparam int USB_TX_ABORT_BITS_N = 7;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        ABORT,
        EOP
    } usb_tx_state_t;

    function automatic usb_line_state_t usb_toggle(input usb_line_state_t lvl);
        return (lvl == LS_J) ? LS_K : LS_J;
    endfunction

endpackage

// File: rtl/usb_tx_nrzi.sv
// NRZI encoder with consecutive-ones tracking; a step taken while stuff_req is set
// emits the stuffed toggle instead of bit_in.
module usb_tx_nrzi
    import usb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            step,
    input  logic            bit_in,
    output usb_line_state_t level,
    output logic            stuff_req
);

    localparam int CW = $clog2(USB_STUFF_BITS_N + 1);

    logic [CW-1:0]   ones_cnt;
    logic [CW-1:0]   prev_cnt;
    usb_line_state_t prev_level;
    logic            stuff_now;

    // clr lets the first bit of a packet be encoded against idle J in the same cycle.
    assign prev_level = clr ? LS_J : level;
    assign prev_cnt   = clr ? '0 : ones_cnt;
    assign stuff_now  = (prev_cnt == CW'(USB_STUFF_BITS_N));
    assign stuff_req  = (ones_cnt == CW'(USB_STUFF_BITS_N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level    <= LS_J;
            ones_cnt <= '0;
        end else if (step) begin
            if (stuff_now || !bit_in) begin
                level    <= usb_toggle(prev_level);
                ones_cnt <= '0;
            end else begin
                level    <= prev_level;
                ones_cnt <= prev_cnt + CW'(1);
            end
        end else if (clr) begin
            level    <= LS_J;
            ones_cnt <= '0;
        end
    end

endmodule

// File: rtl/usb_tx_seq.sv
// USB transmit sequencer: SYNC, NRZI/bit-stuffed payload, EOP.
// Define USB_TX_ABORT_EN to turn payload underflow into a tx_err pulse plus an abort run.
module usb_tx_seq
    import usb_pkg::*;
#(
    parameter int CLK_PER_BIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tx_start,
    input  logic [7:0]      tx_data,
    input  logic            tx_valid,
    input  logic            tx_last,
    output logic            tx_ready,
    output usb_line_state_t line_state,
    output logic            line_oe,
    output logic            busy,
    output logic            tx_err
);

    usb_tx_state_t   state, state_nxt;
    logic [7:0]      bit_cnt;
    logic [3:0]      bits_sent, bits_nxt;
    logic [7:0]      shreg;
    logic            last_q;
    logic            load;
    logic            nz_step, nz_clr, nz_bit;
    usb_line_state_t nz_level;
    logic            stuff_req;
    logic            bit_end;
    logic            unit_done;

    assign bit_end   = (bit_cnt == 8'(CLK_PER_BIT - 1));
    assign unit_done = (bits_sent == 4'd8) && !stuff_req;

    usb_tx_nrzi u_nrzi (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (nz_clr),
        .step      (nz_step),
        .bit_in    (nz_bit),
        .level     (nz_level),
        .stuff_req (stuff_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            bits_sent <= '0;
            shreg     <= '0;
            last_q    <= 1'b0;
        end else begin
            if (state == IDLE || bit_end) bit_cnt <= '0;
            else                          bit_cnt <= bit_cnt + 8'd1;
            bits_sent <= bits_nxt;
            if (load) begin
                shreg  <= tx_data;
                last_q <= tx_last;
            end
        end
    end

    // Every decision is taken on the last clock of a bit period, so the line only moves there.
    always_comb begin
        state_nxt = state;
        bits_nxt  = bits_sent;
        load      = 1'b0;
        nz_step   = 1'b0;
        nz_clr    = 1'b0;
        nz_bit    = 1'b1;
        case (state)
            IDLE: begin
                if (tx_start) begin
                    state_nxt = SYNC;
                    nz_clr    = 1'b1;
                    nz_step   = 1'b1;
                    nz_bit    = (USB_SYNC_PATTERN[7] == 2'(LS_J));
                    bits_nxt  = 4'd1;
                end
            end
            SYNC, DATA: begin
                if (bit_end) begin
                    if (stuff_req) begin
                        nz_step = 1'b1;
                    end else if (bits_sent != 4'd8) begin
                        nz_step  = 1'b1;
                        nz_bit   = (state == SYNC)
                                 ? (USB_SYNC_PATTERN[3'd7 - bits_sent[2:0]] == 2'(nz_level))
                                 : shreg[bits_sent[2:0]];
                        bits_nxt = bits_sent + 4'd1;
                    end else if (state == DATA && last_q) begin
                        state_nxt = EOP;
                        bits_nxt  = '0;
                    end else if (tx_valid) begin
                        state_nxt = DATA;
                        load      = 1'b1;
                        nz_step   = 1'b1;
                        nz_bit    = tx_data[0];
                        bits_nxt  = 4'd1;
                    end else begin
`ifdef USB_TX_ABORT_EN
                        state_nxt = ABORT;
`else
                        state_nxt = EOP;
`endif
                        bits_nxt  = '0;
                    end
                end
            end
            ABORT: begin
                if (bit_end) begin
                    if (bits_sent == 4'(USB_TX_ABORT_BITS_N - 1)) begin
                        state_nxt = EOP;
                        bits_nxt  = '0;
                    end else begin
                        bits_nxt  = bits_sent + 4'd1;
                    end
                end
            end
            EOP: begin
                if (bit_end) begin
                    if (bits_sent == 4'd2) begin
                        state_nxt = IDLE;
                        bits_nxt  = '0;
                    end else begin
                        bits_nxt  = bits_sent + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        line_oe    = busy;
        tx_ready   = bit_end && unit_done && (state == SYNC || (state == DATA && !last_q));
        line_state = LS_J;
        case (state)
            SYNC, DATA, ABORT: line_state = nz_level;
            EOP:               line_state = usb_line_state_t'(USB_EOP_PATTERN[2'd2 - bits_sent[1:0]]);
            default:           line_state = LS_J;
        endcase
`ifdef USB_TX_ABORT_EN
        tx_err = tx_ready && !tx_valid;
`else
        tx_err = 1'b0;
`endif
    end

endmodule

// File: tb/tb_usb_tx_seq.sv
// Directed bench for usb_tx_seq: expected line bits are queued per packet and checked every clock.
module tb_usb_tx_seq;
    import usb_pkg::*;

    localparam int CPB = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            tx_start = 1'b0;
    logic [7:0]      tx_data = 8'h00;
    logic            tx_valid = 1'b0;
    logic            tx_last = 1'b0;
    logic            tx_ready;
    usb_line_state_t line_state;
    logic            line_oe;
    logic            busy;
    logic            tx_err;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_q[$];
    logic [7:0] pkt[4];
    int         npkt;
    bit         pkt_last;

    usb_tx_seq #(.CLK_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .line_state (line_state),
        .line_oe    (line_oe),
        .busy       (busy),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_bit(inout logic [1:0] lvl, inout int ones, input logic b);
        if (b) ones++;
        else begin
            lvl  = (lvl == 2'(LS_J)) ? 2'(LS_K) : 2'(LS_J);
            ones = 0;
        end
        exp_q.push_back(lvl);
        if (ones == 6) begin
            lvl  = (lvl == 2'(LS_J)) ? 2'(LS_K) : 2'(LS_J);
            ones = 0;
            exp_q.push_back(lvl);
        end
    endtask

    task automatic build_expected();
        logic [1:0] lvl;
        int         ones;
        lvl  = 2'(LS_J);
        ones = 0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) model_bit(lvl, ones, (i == 7));
        for (int i = 0; i < npkt; i++)
            for (int b = 0; b < 8; b++) model_bit(lvl, ones, pkt[i][b]);
`ifdef USB_TX_ABORT_EN
        if (!pkt_last) repeat (7) exp_q.push_back(lvl);
`endif
        exp_q.push_back(2'(LS_SE0));
        exp_q.push_back(2'(LS_SE0));
        exp_q.push_back(2'(LS_J));
    endtask

    task automatic present(input int bi);
        if (bi < npkt) begin
            tx_valid = 1'b1;
            tx_data  = pkt[bi];
            tx_last  = pkt_last && (bi == npkt - 1);
        end else begin
            tx_valid = 1'b0;
            tx_data  = 8'h00;
            tx_last  = 1'b0;
        end
    endtask

    task automatic run_packet(input int start_at, input int reset_at, input int exp_gap);
        int  nbits, bi, sub, oe_cycles, rc, err_cnt;
        int  r_cyc[8];
        bit  done, aborted, xfer;
        build_expected();
        nbits = exp_q.size();
        bi = 0; sub = 0; oe_cycles = 0; rc = 0; err_cnt = 0;
        done = 0; aborted = 0; xfer = 0;
        present(0);
        tx_start = 1'b1;
        for (int cyc = 1; cyc <= 600 && !done; cyc++) begin
            @(posedge clk); #1;
            tx_start = (cyc == start_at);
            if (xfer) begin
                bi++;
                present(bi);
            end
            if (cyc == reset_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_oe", line_oe, 0);
                check("rst_line", line_state, LS_J);
                check("rst_busy", busy, 0);
                check("rst_ready", tx_ready, 0);
                aborted = 1;
                done    = 1;
            end else begin
                #1;
                if (cyc == 1) check("start_oe", line_oe, 1);
                if (!line_oe) done = 1;
                else begin
                    oe_cycles++;
                    if (exp_q.size() == 0) check("line_extra", line_oe, 0);
                    else begin
                        check("line", line_state, exp_q[0]);
                        sub++;
                        if (sub == CPB) begin
                            void'(exp_q.pop_front());
                            sub = 0;
                        end
                    end
                end
                if (tx_ready && rc < 8) begin
                    r_cyc[rc] = cyc;
                    rc++;
                end
                if (tx_err) err_cnt++;
                xfer = tx_ready && tx_valid;
            end
        end
        tx_start = 1'b0;
        if (aborted) begin
            exp_q.delete();
            present(npkt);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            @(posedge clk); #1;
            check("post_rst_busy", busy, 0);
        end else begin
            check("done", done, 1);
            check("exp_empty", exp_q.size(), 0);
            check("oe_cycles", oe_cycles, nbits * CPB);
            check("ready_cnt", rc, pkt_last ? npkt : npkt + 1);
            if (rc > 0) check("sync_ready_cyc", r_cyc[0], 8 * CPB);
            if (exp_gap > 0 && rc >= 2) check("ready_gap", r_cyc[1] - r_cyc[0], exp_gap);
`ifdef USB_TX_ABORT_EN
            check("err_cnt", err_cnt, pkt_last ? 0 : 1);
`else
            check("err_cnt", err_cnt, 0);
`endif
            oe_cycles = 0;
            repeat (10) begin
                @(posedge clk); #1;
                if (line_oe || line_state != LS_J || busy) oe_cycles++;
            end
            check("idle_quiet", oe_cycles, 0);
        end
    endtask

    initial begin
        #2;
        check("reset_line", line_state, LS_J);
        check("reset_oe", line_oe, 0);
        check("reset_busy", busy, 0);
        check("reset_ready", tx_ready, 0);
        check("reset_err", tx_err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        npkt = 1; pkt_last = 1; pkt[0] = 8'h00;
        run_packet(-1, -1, -1);

        npkt = 1; pkt_last = 1; pkt[0] = 8'hFF;
        run_packet(-1, -1, -1);

        npkt = 2; pkt_last = 1; pkt[0] = 8'hA5; pkt[1] = 8'h3C;
        run_packet(-1, -1, 8 * CPB);

        npkt = 1; pkt_last = 1; pkt[0] = 8'hFC;
        run_packet(-1, -1, -1);

        npkt = 3; pkt_last = 1; pkt[0] = 8'hF0; pkt[1] = 8'hFF; pkt[2] = 8'h7E;
        run_packet(-1, -1, -1);

        npkt = 1; pkt_last = 0; pkt[0] = 8'h12;
        run_packet(-1, -1, -1);

        npkt = 1; pkt_last = 1; pkt[0] = 8'hA5;
        run_packet(-1, 50, -1);

        npkt = 1; pkt_last = 1; pkt[0] = 8'h00;
        run_packet(-1, -1, -1);

        npkt = 1; pkt_last = 1; pkt[0] = 8'h5A;
        run_packet(45, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
